// File: rtl/sram_controller.sv
// Memory-stage data-memory controller: each 32-bit access becomes two 16-bit async SRAM transfers.
// Optional macro SRAM_POSTED_WRITE_EN: writes complete in the background without freezing the pipeline.
module sram_controller #(
  parameter int ADDR_OFFSET = 1024,
  parameter int SRAM_ADDR_W = 18,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   readEnabled,
  input  logic                   writeEnabled,
  input  logic [31:0]            address,
  input  logic [31:0]            writeData,
  output logic [31:0]            readData,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sramAddress,
  output logic [15:0]            sramDqOut,
  input  logic [15:0]            sramDqIn,
  output logic                   sramDqOe,
  output logic                   sramWeN,
  output logic                   sramOeN
);

  localparam int WORD_W = SRAM_ADDR_W - 1;
  localparam int CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

`ifdef SRAM_POSTED_WRITE_EN
  localparam logic POSTED = 1'b1;
`else
  localparam logic POSTED = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2, DONE = 2'd3} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WORD_W-1:0]      word_q, word_d;
  logic [31:0]            data_q, data_d;
  logic                   wr_q, wr_d;
  logic [31:0]            read_data_q, read_data_d;
  logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [15:0]            dq_out_q, dq_out_d;
  logic                   dq_oe_q, dq_oe_d;
  logic                   we_n_q, we_n_d;
  logic                   oe_n_q, oe_n_d;
  logic                   req_s;
  logic [WORD_W-1:0]      req_word_s;

  // Out-of-range addresses simply wrap onto the SRAM word space.
  assign req_s      = readEnabled | writeEnabled;
  assign req_word_s = WORD_W'((address - 32'(ADDR_OFFSET)) >> 2);

  // Freeze request back to the pipeline; combinational so IDLE can stall in the request cycle.
  always_comb begin
    ready = 1'b0;
    if (rst) begin
      ready = 1'b1;
    end else begin
      case (state_q)
        IDLE:      ready = ~req_s | (POSTED & writeEnabled);
        LOW, HIGH: ready = (POSTED & wr_q) ? ~req_s : 1'b0;
        DONE:      ready = 1'b1;
        default:   ready = 1'b0;
      endcase
    end
  end

  // Next-state, latching and read capture, then SRAM pins decoded from the next state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    data_d      = data_q;
    wr_d        = wr_q;
    read_data_d = read_data_q;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          word_d  = req_word_s;
          data_d  = writeData;
          wr_d    = writeEnabled;
          cnt_d   = {CNT_W{1'b0}};
          state_d = LOW;
        end else begin
          state_d = IDLE;
        end
      end
      LOW: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = HIGH;
          if (!wr_q) begin
            read_data_d[15:0] = sramDqIn;
          end else begin
            read_data_d = read_data_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HIGH: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = (POSTED && wr_q) ? IDLE : DONE;
          if (!wr_q) begin
            read_data_d[31:16] = sramDqIn;
          end else begin
            read_data_d = read_data_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;
    dq_oe_d     = 1'b0;
    we_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    case (state_d)
      LOW, HIGH: begin
        sram_addr_d = {word_d, (state_d == HIGH)};
        if (wr_d) begin
          we_n_d   = 1'b0;
          dq_oe_d  = 1'b1;
          dq_out_d = (state_d == HIGH) ? data_d[31:16] : data_d[15:0];
        end else begin
          oe_n_d = 1'b0;
        end
      end
      default: begin
        sram_addr_d = sram_addr_q;
      end
    endcase
  end

  // State and registered SRAM pins; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      word_q      <= {WORD_W{1'b0}};
      data_q      <= 32'h0000_0000;
      wr_q        <= 1'b0;
      read_data_q <= 32'h0000_0000;
      sram_addr_q <= {SRAM_ADDR_W{1'b0}};
      dq_out_q    <= 16'h0000;
      dq_oe_q     <= 1'b0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      data_q      <= data_d;
      wr_q        <= wr_d;
      read_data_q <= read_data_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
    end
  end

  assign readData    = read_data_q;
  assign sramAddress = sram_addr_q;
  assign sramDqOut   = dq_out_q;
  assign sramDqOe    = dq_oe_q;
  assign sramWeN     = we_n_q;
  assign sramOeN     = oe_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: directed accesses against a small SRAM model; a negedge monitor
// pops expected readData/stall length from a scoreboard whenever a request completes.
module tb_sram_controller;

`ifdef SRAM_POSTED_WRITE_EN
  localparam int WR_LAT = 0;
`else
  localparam int WR_LAT = 5;
`endif

  typedef struct {
    logic [31:0] rd;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        readEnabled = 1'b0;
  logic        writeEnabled = 1'b0;
  logic [31:0] address = 32'h0;
  logic [31:0] writeData = 32'h0;
  logic [31:0] readData;
  logic        ready;
  logic [17:0] sramAddress;
  logic [15:0] sramDqOut;
  logic [15:0] sramDqIn;
  logic        sramDqOe;
  logic        sramWeN;
  logic        sramOeN;

  int checks = 0;
  int failures = 0;
  int low_cnt = 0;
  int starts = 0;
  logic prev_oe_n = 1'b1;
  logic mon_en = 1'b1;
  exp_t sb[$];
  exp_t mon_e;
  logic [17:0] addr_log[$];
  logic [15:0] mem [0:63];

  sram_controller #(.ADDR_OFFSET(1024), .SRAM_ADDR_W(18), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .readEnabled(readEnabled), .writeEnabled(writeEnabled),
    .address(address), .writeData(writeData), .readData(readData), .ready(ready),
    .sramAddress(sramAddress), .sramDqOut(sramDqOut), .sramDqIn(sramDqIn),
    .sramDqOe(sramDqOe), .sramWeN(sramWeN), .sramOeN(sramOeN)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
  end

  always @(posedge clk) begin
    if (!sramWeN && sramDqOe) mem[sramAddress[5:0]] <= sramDqOut;
  end
  assign sramDqIn = !sramOeN ? mem[sramAddress[5:0]] : 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: completion is a request seen with ready=1.
  always @(negedge clk) begin
    if (!rst && mon_en && (readEnabled || writeEnabled)) begin
      if (!ready) begin
        low_cnt++;
      end else begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty actual=completion required=none");
        end else begin
          mon_e = sb.pop_front();
          check("read_data", readData, mon_e.rd);
          check("stall_cycles", 32'(low_cnt), 32'(mon_e.lat));
        end
        low_cnt = 0;
      end
    end else begin
      low_cnt = 0;
    end
  end

  // Access-start counter and SRAM address trace.
  always @(negedge clk) begin
    if (prev_oe_n && !sramOeN) starts++;
    prev_oe_n = sramOeN;
    if ((!sramWeN || !sramOeN) && (addr_log.size() == 0 || addr_log[$] != sramAddress))
      addr_log.push_back(sramAddress);
  end

  task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input int lat);
    exp_t e;
    int n;
    e.rd = exp_rd;
    e.lat = lat;
    sb.push_back(e);
    writeEnabled = wr;
    readEnabled = ~wr;
    address = a;
    writeData = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready && n < 40);
    if (!ready) begin
      checks++;
      failures++;
      $display("FAIL access_timeout actual=ready_low required=ready_high addr=%h", a);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    readEnabled = 1'b0;
    writeEnabled = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    readEnabled = 1'b1;
    address = 32'd1024;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    @(negedge clk);
    check("rst_we_n", 32'(sramWeN), 32'd1);
    check("rst_oe_n", 32'(sramOeN), 32'd1);
    check("rst_dq_oe", 32'(sramDqOe), 32'd0);
    check("rst_read_data", readData, 32'h0);
    check("rst_sram_addr", 32'(sramAddress), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    readEnabled = 1'b0;
    #1;
    check("idle_ready", 32'(ready), 32'd1);
    idle(1);

    access(1'b1, 32'd1024, 32'hDEADBEEF, 32'h0, WR_LAT);
    idle(6);
    check("mem0", 32'(mem[0]), 32'h0000BEEF);
    check("mem1", 32'(mem[1]), 32'h0000DEAD);

    access(1'b0, 32'd1024, 32'h0, 32'hDEADBEEF, 5);
    idle(2);

    addr_log.delete();
    access(1'b1, 32'd1032, 32'h12345678, 32'hDEADBEEF, WR_LAT);
    idle(6);
    check("addr_log_len", 32'(addr_log.size()), 32'd2);
    if (addr_log.size() == 2) begin
      check("addr_low", 32'(addr_log[0]), 32'd4);
      check("addr_high", 32'(addr_log[1]), 32'd5);
    end
    access(1'b0, 32'd1032, 32'h0, 32'h12345678, 5);
    idle(2);

    mon_en = 1'b0;
    writeEnabled = 1'b1;
    address = 32'd1040;
    writeData = 32'hA5A5C3C3;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_ready_in_rst", 32'(ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    writeEnabled = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_we_n", 32'(sramWeN), 32'd1);
    check("abort_dq_oe", 32'(sramDqOe), 32'd0);
    check("abort_oe_n", 32'(sramOeN), 32'd1);
    check("abort_partial_low", 32'(mem[8]), 32'h0000C3C3);
    check("abort_read_data", readData, 32'h0);
    idle(2);
    mon_en = 1'b1;

    starts = 0;
    access(1'b0, 32'd1024, 32'h0, 32'hDEADBEEF, 5);
    access(1'b0, 32'd1032, 32'h0, 32'h12345678, 5);
    idle(6);
    check("b2b_starts", 32'(starts), 32'd2);

`ifdef SRAM_POSTED_WRITE_EN
    access(1'b1, 32'd1048, 32'hCAFEF00D, 32'h12345678, 0);
    access(1'b0, 32'd1048, 32'h0, 32'hCAFEF00D, 9);
    idle(2);
    check("posted_mem12", 32'(mem[12]), 32'h0000F00D);
    check("posted_mem13", 32'(mem[13]), 32'h0000CAFE);
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
